// File: rtl/bin_to_dec_seq.sv
// Sequential binary to packed-BCD converter: successive subtraction of decimal weights,
// one compare/subtract per clock, with signed mode, overflow saturation and significance mask.
module bin_to_dec_seq #(
    parameter int unsigned BIN_W = 32,
    parameter int unsigned NDIG  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st,
    input  logic [BIN_W-1:0]           BIN,
    input  logic                       sgn,
    output logic [4*NDIG-1:0]          DEC,
    output logic                       neg,
    output logic                       ovf,
    output logic [NDIG-1:0]            nz_mask,
    output logic [$clog2(NDIG+1)-1:0]  ptr_dig,
    output logic                       en_conv,
    output logic                       ok_conv
);

    localparam int unsigned PW = $clog2(NDIG + 1);

    function automatic logic [67:0] pow10(input int unsigned e);
        logic [67:0] r;
        r = 68'd1;
        for (int unsigned k = 0; k < e; k++) begin
            r = r * 68'd10;
        end
        return r;
    endfunction

    localparam logic [67:0] LIM = pow10(NDIG);

    // Digit i is significant when it or any higher digit is nonzero; digit 0 always shown.
    function automatic logic [NDIG-1:0] sig_mask(input logic [4*NDIG-1:0] d);
        logic [NDIG-1:0] m;
        logic            seen;
        m    = '0;
        seen = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            seen = seen | (d[4*i +: 4] != 4'd0);
            m[i] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    typedef enum logic {StIdle, StConv} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [67:0]         rest_q, rest_d;
    logic [4*NDIG-1:0]   dig_q, dig_d;
    logic                sign_q, sign_d;
    logic [4*NDIG-1:0]   dec_q, dec_d;
    logic                neg_q, neg_d;
    logic                ovf_q, ovf_d;
    logic [NDIG-1:0]     nz_q, nz_d;
    logic                ok_q, ok_d;

    logic                neg_in;
    logic [BIN_W:0]      mag;
    logic [67:0]         mag_ext;
    logic [67:0]         w_cur;
    logic [4*NDIG-1:0]   dig_inc;

    // Extra bit keeps the magnitude of the most negative operand exact.
    assign neg_in  = sgn & BIN[BIN_W-1];
    assign mag     = neg_in ? -{BIN[BIN_W-1], BIN} : {1'b0, BIN};
    assign mag_ext = 68'(mag);

    always_comb begin
        w_cur   = '0;
        dig_inc = dig_q;
        for (int unsigned p = 1; p <= NDIG; p++) begin
            if (ptr_q == PW'(p)) begin
                w_cur                  = pow10(p - 1);
                dig_inc[4*(p-1) +: 4]  = dig_q[4*(p-1) +: 4] + 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rest_d  = rest_q;
        dig_d   = dig_q;
        sign_d  = sign_q;
        dec_d   = dec_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        nz_d    = nz_q;
        ok_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (st) begin
                    if (mag_ext >= LIM) begin
                        dec_d = {NDIG{4'h9}};
                        ovf_d = 1'b1;
                        neg_d = neg_in;
                        nz_d  = '1;
                        ok_d  = 1'b1;
                    end else begin
                        rest_d  = mag_ext;
                        dig_d   = '0;
                        ptr_d   = PW'(NDIG);
                        sign_d  = neg_in;
                        state_d = StConv;
                    end
                end
            end
            StConv: begin
                if (rest_q >= w_cur) begin
                    rest_d = rest_q - w_cur;
                    dig_d  = dig_inc;
                end else begin
                    ptr_d = ptr_q - PW'(1);
                    if (ptr_q == PW'(1)) begin
                        state_d = StIdle;
                        ok_d    = 1'b1;
                        dec_d   = dig_q;
                        neg_d   = sign_q;
                        ovf_d   = 1'b0;
                        nz_d    = sig_mask(dig_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            rest_q  <= '0;
            dig_q   <= '0;
            sign_q  <= 1'b0;
            dec_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            nz_q    <= NDIG'(1);
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rest_q  <= rest_d;
            dig_q   <= dig_d;
            sign_q  <= sign_d;
            dec_q   <= dec_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            nz_q    <= nz_d;
            ok_q    <= ok_d;
        end
    end

    assign DEC     = dec_q;
    assign neg     = neg_q;
    assign ovf     = ovf_q;
    assign nz_mask = nz_q;
    assign ptr_dig = ptr_q;
    assign en_conv = (state_q == StConv);
    assign ok_conv = ok_q;

endmodule

// File: doc/bin_to_dec_seq.md
Name: bin_to_dec_seq

Overview:
- Parametrised sequential binary-to-packed-BCD converter using successive subtraction of decimal weights, one compare/subtract per clock.
- Generalises the fixed 32-bit/8-digit converter in three ways:
  - width and digit count are parameters;
  - runtime signed mode;
  - overflow saturation and a leading-zero significance mask for display drivers.
- Sits between arithmetic/counter logic and the 7-segment display multiplexer.

Parameters:
- BIN_W, 32, input binary width; legal range 4..64.
- NDIG, 8, number of decimal digits produced; legal range 1..19.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- st  in  1  start strobe, sampled each clk; honoured only when en_conv=0.
- BIN  in  BIN_W  binary operand, sampled on the accepted st edge.
- sgn  in  1  sampled with BIN. 1 = BIN is two's complement; 0 = unsigned.
- DEC  out  4*NDIG  packed BCD result, digit NDIG-1 in the MSBs; held between conversions.
- neg  out  1  sign of the last result.
- ovf  out  1  last result overflowed, i.e. magnitude >= 10^NDIG.
- nz_mask  out  NDIG  bit i=1 if digit i is significant (digit i or any higher digit nonzero); bit 0 always 1.
- ptr_dig  out  clog2(NDIG+1)  current digit pointer (NDIG..1 while converting, 0 when idle).
- en_conv  out  1  busy.
- ok_conv  out  1  one-cycle done pulse.

Behaviour:
- Reset (rst=1 at an edge): DEC=0, neg=0, ovf=0, nz_mask=1 (bit 0 only), ptr_dig=0, en_conv=0, ok_conv=0, internal digits/remainder cleared.
  - rst has priority over st.
  - rst mid-conversion aborts: no ok_conv, and DEC is cleared.
- Internal arithmetic is 68-bit unsigned. Weight W(p)=10^(p-1), constant-computed for p=1..NDIG. Limit LIM=10^NDIG.
- Load (edge where st=1 and en_conv=0):
  - mag = (sgn & BIN[BIN_W-1]) ? -BIN : BIN, computed BIN_W+1 wide so that the minimum negative value is exact.
  - neg_int = sgn & BIN[BIN_W-1].
  - If mag >= LIM:
    - DEC = all digits 9, ovf=1, neg=neg_int, nz_mask all ones, ok_conv=1, en_conv stays 0.
    - This is the only case with no conversion cycles.
  - Otherwise:
    - rest=mag, digits=0, ptr_dig=NDIG, en_conv=1.
    - DEC, neg, ovf and nz_mask hold their old values.
- st while en_conv=1 is ignored; the conversion in progress is unaffected and BIN/sgn are not resampled.
- Convert: one operation per edge while en_conv=1.
  - If rest >= W(ptr_dig): rest -= W(ptr_dig) and digit[ptr_dig-1]++. ptr_dig is unchanged.
  - Else: ptr_dig--.
  - On the edge where ptr_dig goes 1->0:
    - en_conv=0 and ok_conv=1.
    - DEC = assembled digits, neg=neg_int, ovf=0, nz_mask computed from the final digits.
- A digit never exceeds 9, guaranteed by the load-time LIM check.
- ok_conv is high for exactly one cycle per completion, including overflow completions; otherwise 0.
- Latency: let S = sum of the decimal digits of mag. The completion edge is S+NDIG edges after the accepted st edge, so ok_conv is high in the cycle after that edge.
  - Overflow completion is 0 edges after the st edge, i.e. ok_conv is high in the next cycle.
- st in the same cycle that ok_conv is high is accepted, because en_conv is already 0.
- Zero input: DEC=0, neg=0, nz_mask=1.
- With sgn=0, the MSB of BIN is plain magnitude.

Test Plan:
- NDIG=8, BIN=0, sgn=0 -> ok_conv 8 edges after st; DEC=0x00000000, nz_mask=0x01, neg=0, ovf=0.
- BIN=12345678 -> latency 36+8=44 edges; DEC=0x12345678, nz_mask=0xFF; ptr_dig steps 8..0 monotonically; en_conv falls on the ok_conv edge.
- BIN=0xFFFFFFF6, sgn=1 (-10) -> DEC=0x00000010, neg=1, nz_mask=0x03, latency 9. Then BIN=0x80000000, sgn=1 -> ovf=1, DEC=0x99999999, neg=1, ok_conv the cycle after st.
- BIN=100000000, sgn=0 -> ovf=1, DEC=0x99999999, nz_mask=0xFF, one-cycle ok_conv. Then BIN=99999999 -> ovf=0, DEC=0x99999999, latency 80.
- Start 12345678, pulse st with BIN=5 at cycle 10 -> ignored, result still 0x12345678 at 44. Start again, assert rst at cycle 20 -> en_conv=0, no ok_conv, DEC=0, nz_mask=0x01.
- BIN_W=16, NDIG=5, BIN=0xFFFF, sgn=0 -> DEC=0x65535, latency 24+5=29. Same params with sgn=1, BIN=0x8000 -> DEC=0x32768, neg=1, nz_mask=0x1F.
